uart_cmd_ctrl: RTL

Command sequencer between the UART byte datapath (uart_rx / uart_tx) and the arm's servo setpoint logic. It consumes received bytes through the uart_rx converted/valid/flush handshake and frames them into fixed 5-byte command packets. Each packet is validated for checksum, servo ID and inter-byte timeout. The block issues a one-cycle command strobe to the servo side and schedules a 2-byte ACK/NAK reply through uart_tx's enable/busy handshake.

---
 rtl/uart_cmd_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl
//   Command sequencer between the UART byte datapath and the servo setpoint
//   logic. Frames received bytes into 5-byte packets
//   (HEADER, ID, HI, LO, CK with CK = ID ^ HI ^ LO), validates checksum, servo
//   ID and inter-byte timeout, strobes validated commands to the servo side and
//   sends a 2-byte ACK (06, ID) or NAK (15, code) reply through uart_tx.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   rx_data/rx_converted/    byte and frame-status handshake from uart_rx
//   rx_valid
//   rx_flush                 one-cycle pulse releasing the byte held in uart_rx
//   tx_data/tx_enable        reply byte and one-cycle start pulse to uart_tx
//   tx_busy                  uart_tx transmitting
//   cmd_valid                one-cycle strobe for a new validated command
//   cmd_id/cmd_value         servo index and {hi,lo} setpoint of last command
//   err_count                saturating count of NAKed packets
//   busy                     high whenever the sequencer is not hunting
// -----------------------------------------------------------------------------
module uart_cmd_ctrl #(
    parameter int         N_SERVO        = 6,
    parameter int         ID_W           = 3,
    parameter logic [7:0] HEADER         = 8'hAA,
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter int         BUSY_GUARD     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      rx_data,
    input  logic            rx_converted,
    input  logic            rx_valid,
    output logic            rx_flush,
    output logic [7:0]      tx_data,
    output logic            tx_enable,
    input  logic            tx_busy,
    output logic            cmd_valid,
    output logic [ID_W-1:0] cmd_id,
    output logic [15:0]     cmd_value,
    output logic [7:0]      err_count,
    output logic            busy
);

    localparam int             TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam int             GRD_W      = $clog2(BUSY_GUARD + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [GRD_W-1:0] GRD_LIMIT = GRD_W'(BUSY_GUARD);
    localparam logic [7:0]     N_SERVO_ID = 8'(N_SERVO);

    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;
    localparam logic [7:0] NAK_CK   = 8'h01;
    localparam logic [7:0] NAK_ID   = 8'h02;
    localparam logic [7:0] NAK_TMO  = 8'h03;
    localparam logic [7:0] NAK_LINE = 8'h04;

    typedef enum logic [3:0] {
        ST_HUNT       = 4'd0,
        ST_GET_ID     = 4'd1,
        ST_GET_HI     = 4'd2,
        ST_GET_LO     = 4'd3,
        ST_GET_CK     = 4'd4,
        ST_EXEC       = 4'd5,
        ST_TX_LOAD    = 4'd6,
        ST_TX_WAIT_HI = 4'd7,
        ST_TX_WAIT_LO = 4'd8
    } state_t;

    // Packet check byte: XOR of the three payload bytes.
    function automatic logic [7:0] calc_ck(input logic [7:0] id,
                                           input logic [7:0] hi,
                                           input logic [7:0] lo);
        return id ^ hi ^ lo;
    endfunction

    // Successor of a byte-collecting state once its byte has been taken.
    function automatic state_t next_get(input state_t s);
        state_t n;
        case (s)
            ST_GET_ID: n = ST_GET_HI;
            ST_GET_HI: n = ST_GET_LO;
            ST_GET_LO: n = ST_GET_CK;
            ST_GET_CK: n = ST_EXEC;
            default:   n = ST_HUNT;
        endcase
        return n;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;

    logic             rx_flush_r;
    logic             ign_r;
    logic [7:0]       id_r;
    logic [7:0]       hi_r;
    logic [7:0]       lo_r;
    logic [7:0]       ck_r;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic [GRD_W-1:0] grd_cnt_r;
    logic             resp_idx_r;
    logic [7:0]       resp_hdr_r;
    logic [7:0]       resp_arg_r;
    logic [7:0]       tx_data_r;
    logic             tx_enable_r;
    logic             cmd_valid_r;
    logic [ID_W-1:0]  cmd_id_r;
    logic [15:0]      cmd_value_r;
    logic [7:0]       err_count_r;
    logic             busy_r;

    logic             in_get_s;
    logic             rx_open_s;
    logic             rx_blocked_s;
    logic             accept_s;
    logic             line_err_s;
    logic             timeout_s;
    logic             start_resp_s;
    logic             nak_s;
    logic             cmd_fire_s;
    logic             tx_fire_s;
    logic             resp_adv_s;
    logic [7:0]       resp_hdr_nxt_s;
    logic [7:0]       resp_arg_nxt_s;

    assign rx_flush  = rx_flush_r;
    assign tx_data   = tx_data_r;
    assign tx_enable = tx_enable_r;
    assign cmd_valid = cmd_valid_r;
    assign cmd_id    = cmd_id_r;
    assign cmd_value = cmd_value_r;
    assign err_count = err_count_r;
    assign busy      = busy_r;

    // Decode which received frame may be taken this cycle and whether the
    // inter-byte timer has expired. A byte stays blocked during the flush
    // cycle and the cycle after, while uart_rx may still show the old frame.
    always_comb begin
        in_get_s     = (state_r == ST_GET_ID) || (state_r == ST_GET_HI) ||
                       (state_r == ST_GET_LO) || (state_r == ST_GET_CK);
        rx_open_s    = in_get_s || (state_r == ST_HUNT);
        rx_blocked_s = rx_flush_r || ign_r;
        accept_s     = rx_open_s && rx_converted && rx_valid && !rx_blocked_s;
        line_err_s   = rx_open_s && rx_converted && !rx_valid && !rx_blocked_s;
        timeout_s    = in_get_s && (tmo_cnt_r >= TMO_LIMIT);
    end

    // Next-state and per-cycle action decode of the packet sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        nak_s          = 1'b0;
        cmd_fire_s     = 1'b0;
        tx_fire_s      = 1'b0;
        resp_adv_s     = 1'b0;
        resp_hdr_nxt_s = NAK_BYTE;
        resp_arg_nxt_s = 8'h00;

        case (state_r)
            ST_HUNT: begin
                // Non-header bytes and line errors are flushed and dropped.
                if (accept_s && (rx_data == HEADER)) begin
                    state_nxt_s = ST_GET_ID;
                end else begin
                    state_nxt_s = ST_HUNT;
                end
            end

            ST_GET_ID, ST_GET_HI, ST_GET_LO, ST_GET_CK: begin
                if (line_err_s) begin
                    nak_s          = 1'b1;
                    resp_arg_nxt_s = NAK_LINE;
                    state_nxt_s    = ST_TX_LOAD;
                end else if (accept_s) begin
                    state_nxt_s = next_get(state_r);
                end else if (timeout_s) begin
                    nak_s          = 1'b1;
                    resp_arg_nxt_s = NAK_TMO;
                    state_nxt_s    = ST_TX_LOAD;
                end else begin
                    state_nxt_s = state_r;
                end
            end

            ST_EXEC: begin
                state_nxt_s = ST_TX_LOAD;
                if (ck_r != calc_ck(id_r, hi_r, lo_r)) begin
                    nak_s          = 1'b1;
                    resp_arg_nxt_s = NAK_CK;
                end else if (id_r >= N_SERVO_ID) begin
                    nak_s          = 1'b1;
                    resp_arg_nxt_s = NAK_ID;
                end else begin
                    cmd_fire_s     = 1'b1;
                    resp_hdr_nxt_s = ACK_BYTE;
                    resp_arg_nxt_s = id_r;
                end
            end

            ST_TX_LOAD: begin
                if (!tx_busy) begin
                    tx_fire_s   = 1'b1;
                    state_nxt_s = ST_TX_WAIT_HI;
                end else begin
                    state_nxt_s = ST_TX_LOAD;
                end
            end

            ST_TX_WAIT_HI: begin
                // Guard keeps a uart_tx that never raises busy from stalling us.
                if (tx_busy || (grd_cnt_r >= GRD_LIMIT)) begin
                    state_nxt_s = ST_TX_WAIT_LO;
                end else begin
                    state_nxt_s = ST_TX_WAIT_HI;
                end
            end

            ST_TX_WAIT_LO: begin
                if (tx_busy) begin
                    state_nxt_s = ST_TX_WAIT_LO;
                end else if (!resp_idx_r) begin
                    resp_adv_s  = 1'b1;
                    state_nxt_s = ST_TX_LOAD;
                end else begin
                    state_nxt_s = ST_HUNT;
                end
            end

            default: begin
                state_nxt_s = ST_HUNT;
            end
        endcase

        start_resp_s = nak_s || cmd_fire_s;
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_HUNT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Receive side: flush pulse, re-take guard and packet byte capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_flush_r <= 1'b0;
            ign_r      <= 1'b0;
            id_r       <= 8'h00;
            hi_r       <= 8'h00;
            lo_r       <= 8'h00;
            ck_r       <= 8'h00;
        end else begin
            rx_flush_r <= accept_s || line_err_s;
            ign_r      <= rx_flush_r;
            if (accept_s) begin
                case (state_r)
                    ST_GET_ID: id_r <= rx_data;
                    ST_GET_HI: hi_r <= rx_data;
                    ST_GET_LO: lo_r <= rx_data;
                    ST_GET_CK: ck_r <= rx_data;
                    default:   id_r <= id_r;
                endcase
            end
        end
    end

    // Inter-byte timer (runs only while collecting) and tx_busy rise guard.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
            grd_cnt_r <= {GRD_W{1'b0}};
        end else begin
            if (!in_get_s || accept_s) begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end else if (tmo_cnt_r < TMO_LIMIT) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end

            if (state_r != ST_TX_WAIT_HI) begin
                grd_cnt_r <= {GRD_W{1'b0}};
            end else if (grd_cnt_r < GRD_LIMIT) begin
                grd_cnt_r <= grd_cnt_r + GRD_W'(1);
            end else begin
                grd_cnt_r <= grd_cnt_r;
            end
        end
    end

    // Reply scheduling, uart_tx drive and NAK accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_idx_r  <= 1'b0;
            resp_hdr_r  <= 8'h00;
            resp_arg_r  <= 8'h00;
            tx_data_r   <= 8'h00;
            tx_enable_r <= 1'b0;
            err_count_r <= 8'h00;
        end else begin
            if (start_resp_s) begin
                resp_idx_r <= 1'b0;
                resp_hdr_r <= resp_hdr_nxt_s;
                resp_arg_r <= resp_arg_nxt_s;
            end else if (resp_adv_s) begin
                resp_idx_r <= 1'b1;
            end else begin
                resp_idx_r <= resp_idx_r;
            end

            // tx_data only changes on a start pulse, so it holds through busy.
            tx_enable_r <= tx_fire_s;
            if (tx_fire_s) begin
                tx_data_r <= resp_idx_r ? resp_arg_r : resp_hdr_r;
            end

            if (nak_s && (err_count_r != 8'hFF)) begin
                err_count_r <= err_count_r + 8'd1;
            end
        end
    end

    // Servo-side command outputs and the busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid_r <= 1'b0;
            cmd_id_r    <= {ID_W{1'b0}};
            cmd_value_r <= 16'h0000;
            busy_r      <= 1'b0;
        end else begin
            cmd_valid_r <= cmd_fire_s;
            if (cmd_fire_s) begin
                cmd_id_r    <= id_r[ID_W-1:0];
                cmd_value_r <= {hi_r, lo_r};
            end
            busy_r <= (state_nxt_s != ST_HUNT);
        end
    end

endmodule
